// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline-stage registers: slot-occupancy
// states and the bundle widths used by the E->M stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam int unsigned EM_CTRL_W = 4;
  localparam int unsigned EM_DATA_W = 108;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of an elastic stage: a control + data register with a
// load enable and a control-only clear used to turn the slot into a bubble.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = EM_CTRL_W,
  parameter int unsigned DATA_W = EM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr_ctrl,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Clearing only touches ctrl; data is left as-is so a flushed slot
  // still shows its last payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl <= '0;
    end else if (clr_ctrl) begin
      ctrl <= '0;
    end else if (load) begin
      ctrl <= in_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (load && !clr_ctrl) begin
      data <= in_data;
    end
  end

endmodule

// File: rtl/elastic_stage_reg.sv
// Elastic pipeline-stage register with a 2-entry skid buffer, registered
// InReady, synchronous flush and a saturating stall counter.
module elastic_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = EM_CTRL_W,
  parameter int unsigned DATA_W = EM_DATA_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              ResetN,
  input  logic              Flush,
  input  logic              ClrCnt,
  input  logic              InValid,
  output logic              InReady,
  input  logic [CTRL_W-1:0] InCtrl,
  input  logic [DATA_W-1:0] InData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [CTRL_W-1:0] OutCtrl,
  output logic [DATA_W-1:0] OutData,
  output logic [CNT_W-1:0]  StallCnt
);

  state_t state;
  state_t state_nxt;

  logic in_fire;
  logic out_fire;

  logic load_main;
  logic load_skid;
  logic main_from_skid;

  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] main_in_ctrl;
  logic [DATA_W-1:0] main_in_data;

  assign OutValid = (state != ST_EMPTY);
  assign in_fire  = InValid && InReady;
  assign out_fire = OutValid && OutReady;

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Flush overrides every handshake event; slot loads are suppressed and
  // both slots' ctrl is cleared instead.
  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (Flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state_nxt = ST_BUSY;
            load_main = 1'b1;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            state_nxt = ST_FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_nxt      = ST_BUSY;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  always_comb begin
    main_in_ctrl = InCtrl;
    main_in_data = InData;
    if (main_from_skid) begin
      main_in_ctrl = skid_ctrl;
      main_in_data = skid_data;
    end
  end

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk      (CLK),
    .rst_n    (ResetN),
    .load     (load_main),
    .clr_ctrl (Flush),
    .in_ctrl  (main_in_ctrl),
    .in_data  (main_in_data),
    .ctrl     (main_ctrl),
    .data     (main_data)
  );

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk      (CLK),
    .rst_n    (ResetN),
    .load     (load_skid),
    .clr_ctrl (Flush),
    .in_ctrl  (InCtrl),
    .in_data  (InData),
    .ctrl     (skid_ctrl),
    .data     (skid_data)
  );

  // Registered from next state only, so OutReady never reaches InReady
  // combinationally.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      InReady <= 1'b1;
    end else begin
      InReady <= (state_nxt != ST_FULL);
    end
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      StallCnt <= '0;
    end else if (ClrCnt) begin
      StallCnt <= '0;
    end else if (OutValid && !OutReady && (StallCnt != '1)) begin
      StallCnt <= StallCnt + CNT_W'(1);
    end
  end

  assign OutCtrl = OutValid ? main_ctrl : '0;
  assign OutData = main_data;

endmodule

// File: tb/tb_elastic_stage_reg.sv
// Scoreboard bench for elastic_stage_reg: a queue models the in-flight
// entries, and every cycle the outputs are compared against it.
module tb_elastic_stage_reg;
  import pipe_pkg::*;

  localparam int unsigned CW = EM_CTRL_W;
  localparam int unsigned DW = EM_DATA_W;
  localparam int unsigned NW = 4;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } entry_t;

  logic          CLK = 1'b0;
  logic          ResetN;
  logic          Flush;
  logic          ClrCnt;
  logic          InValid;
  logic          InReady;
  logic [CW-1:0] InCtrl;
  logic [DW-1:0] InData;
  logic          OutValid;
  logic          OutReady;
  logic [CW-1:0] OutCtrl;
  logic [DW-1:0] OutData;
  logic [NW-1:0] StallCnt;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  entry_t        q[$];
  logic [DW-1:0] last_main;
  logic [NW-1:0] stall_model;

  elastic_stage_reg #(
    .CTRL_W (CW),
    .DATA_W (DW),
    .CNT_W  (NW)
  ) dut (
    .CLK      (CLK),
    .ResetN   (ResetN),
    .Flush    (Flush),
    .ClrCnt   (ClrCnt),
    .InValid  (InValid),
    .InReady  (InReady),
    .InCtrl   (InCtrl),
    .InData   (InData),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .OutCtrl  (OutCtrl),
    .OutData  (OutData),
    .StallCnt (StallCnt)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [127:0] tmp;
    tmp = {$urandom(), $urandom(), $urandom(), $urandom()};
    return tmp[DW-1:0];
  endfunction

  task automatic model_reset();
    q.delete();
    last_main   = '0;
    stall_model = '0;
  endtask

  task automatic check_outputs();
    logic [CW-1:0] exp_ctrl;
    exp_ctrl = (q.size() > 0) ? q[0].ctrl : '0;
    check_eq("out_valid", 128'(OutValid), 128'(q.size() > 0));
    check_eq("in_ready",  128'(InReady),  128'(q.size() < 2));
    check_eq("out_ctrl",  128'(OutCtrl),  128'(exp_ctrl));
    check_eq("out_data",  128'(OutData),  128'(last_main));
    check_eq("stall_cnt", 128'(StallCnt), 128'(stall_model));
  endtask

  // Called just after a falling edge: check, drive, advance model, clock.
  task automatic cycle(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                       input logic ordy, input logic fl, input logic clr);
    logic   in_fire;
    logic   out_fire;
    entry_t e;
    check_outputs();
    InValid  = iv;
    InCtrl   = ic;
    InData   = id;
    OutReady = ordy;
    Flush    = fl;
    ClrCnt   = clr;
    in_fire  = iv && (q.size() < 2);
    out_fire = (q.size() > 0) && ordy;
    if (clr) stall_model = '0;
    else if ((q.size() > 0) && !ordy && (stall_model != '1)) stall_model = stall_model + 1'b1;
    if (out_fire) void'(q.pop_front());
    if (fl) begin
      q.delete();
    end else if (in_fire) begin
      e.ctrl = ic;
      e.data = id;
      q.push_back(e);
    end
    if (q.size() > 0) last_main = q[0].data;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  logic [DW-1:0] a_data;
  logic [DW-1:0] b_data;

  initial begin
    ResetN   = 1'b0;
    Flush    = 1'b0;
    ClrCnt   = 1'b0;
    InValid  = 1'b0;
    InCtrl   = '0;
    InData   = '0;
    OutReady = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    check_outputs();
    ResetN = 1'b1;

    // Reset mid-stream while FULL with ctrl all-ones
    cycle(1'b1, 4'hF, rand_data(), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'hF, rand_data(), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("full_before_reset", 128'(InReady), 128'(0));
    #2 ResetN = 1'b0;
    #1;
    model_reset();
    check_eq("rst_out_valid", 128'(OutValid), 128'(0));
    check_eq("rst_out_ctrl",  128'(OutCtrl),  128'(0));
    check_eq("rst_in_ready",  128'(InReady),  128'(1));
    check_eq("rst_stall_cnt", 128'(StallCnt), 128'(0));
    @(negedge CLK);
    ResetN = 1'b1;

    // Streaming 1..8 at full rate
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, CW'(i), DW'(i), 1'b1, 1'b0, 1'b0);
      check_eq("stream_data", 128'(OutData), 128'(i));
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Backpressure: A, B stall, then drain in order
    a_data = rand_data();
    b_data = rand_data();
    cycle(1'b1, 4'h3, a_data, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'h5, b_data, 1'b0, 1'b0, 1'b0);
    check_eq("bp_in_ready", 128'(InReady), 128'(0));
    check_eq("bp_head",     128'(OutData), 128'(a_data));
    cycle(1'b1, 4'h7, rand_data(), 1'b1, 1'b0, 1'b0);
    check_eq("bp_second",   128'(OutData), 128'(b_data));
    check_eq("bp_ready_up", 128'(InReady), 128'(1));
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Flush while FULL with a new entry C offered
    cycle(1'b1, 4'h9, rand_data(), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'hA, rand_data(), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'hC, rand_data(), 1'b0, 1'b1, 1'b0);
    check_eq("flush_valid", 128'(OutValid), 128'(0));
    check_eq("flush_ctrl",  128'(OutCtrl),  128'(0));
    check_eq("flush_ready", 128'(InReady),  128'(1));
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

    // Stall counter saturation and clear-over-increment
    cycle(1'b1, 4'h6, rand_data(), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("stall_sat", 128'(StallCnt), 128'(15));
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check_eq("stall_clr", 128'(StallCnt), 128'(0));
    cycle(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);

    // Random valid/ready with occasional flush and counter clear
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(0, 99) < 70), CW'($urandom()), rand_data(),
            ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 2),
            ($urandom_range(0, 99) < 1));
    end
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
